// File: rtl/ts_pcie_pkg.sv
// ts_pcie_pkg: shared FSM states and TS block sizing for the TS-to-PCIe path
package ts_pcie_pkg;
  typedef enum logic [1:0] {IDLE, READ, DRAIN, CLEAR} state_t;
  localparam int TS_WORDS_PER_PKT = 47;
  localparam int DEFAULT_BANK_WORDS = 32 * TS_WORDS_PER_PKT;
endpackage

// File: rtl/ts_skid_fifo.sv
// ts_skid_fifo: flop-based first-word-fall-through FIFO with occupancy count
module ts_skid_fifo #(
  parameter int DEPTH = 4,
  parameter int W = 34
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [W-1:0]             din,
  output logic [W-1:0]             dout,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   cnt
);
  localparam int PW = $clog2(DEPTH);
  logic [W-1:0] mem [DEPTH];
  logic [PW-1:0] wp, rp;
  always_ff @(posedge clk) begin
    if (rst) begin
      wp <= '0;
      rp <= '0;
      cnt <= '0;
    end else begin
      if (push) begin
        mem[wp] <= din;
        wp <= wp + 1'b1;
      end
      if (pop) rp <= rp + 1'b1;
      cnt <= cnt + (PW+1)'(push) - (PW+1)'(pop);
    end
  end
  assign dout = mem[rp];
  assign empty = cnt == '0;
endmodule

// File: rtl/ts_ram_pingpong_reader.sv
// ts_ram_pingpong_reader: drains full ping-pong TS RAM banks into the PCIe DMA stream
module ts_ram_pingpong_reader
  import ts_pcie_pkg::*;
#(
  parameter int BANK_WORDS = DEFAULT_BANK_WORDS,
  parameter int AW = 11,
  parameter int FIFO_DEPTH = 4
) (
  input  logic          clk_pcie,
  input  logic          rst_pcie,
  input  logic          ram_full_1,
  input  logic          ram_full_2,
  output logic          ram_clr_1,
  output logic          ram_clr_2,
  output logic          ram_rd_en,
  output logic [AW:0]   ram_rd_addr,
  input  logic [31:0]   ram_rd_data,
  input  logic          dma_ready,
  output logic [31:0]   dma_dout,
  output logic          dma_dout_en,
  output logic          dma_sof,
  output logic          dma_eof,
  output logic          busy,
  output logic [15:0]   bank_cnt
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  state_t state, state_n;
  logic bank, last_bank, pick, inflight, tag_sof, tag_eof, pop, empty, last_addr;
  logic [AW-1:0] word_addr;
  logic [CW-1:0] fifo_cnt;
  logic [CW:0] level;
  logic [33:0] head;
  always_comb begin
    pick = (ram_full_1 & ram_full_2) ? ~last_bank : ram_full_2;
    level = {1'b0, fifo_cnt} + {{CW{1'b0}}, inflight};
    last_addr = word_addr == AW'(BANK_WORDS - 1);
    ram_rd_en = (state == READ) && (level < (CW+1)'(FIFO_DEPTH));
    pop = dma_dout_en & dma_ready;
    state_n = state;
    case (state)
      IDLE:    state_n = (ram_full_1 | ram_full_2) ? READ : IDLE;
      READ:    state_n = (ram_rd_en & last_addr) ? DRAIN : READ;
      DRAIN:   state_n = (pop & dma_eof) ? CLEAR : DRAIN;
      default: state_n = IDLE;
    endcase
  end
  // Read data lands one cycle after the strobe, so the sof/eof tags are delayed to match it
  always_ff @(posedge clk_pcie) begin
    if (rst_pcie) begin
      state <= IDLE;
      bank <= 1'b0;
      last_bank <= 1'b1;
      word_addr <= '0;
      inflight <= 1'b0;
      tag_sof <= 1'b0;
      tag_eof <= 1'b0;
      bank_cnt <= '0;
    end else begin
      state <= state_n;
      inflight <= ram_rd_en;
      tag_sof <= word_addr == '0;
      tag_eof <= last_addr;
      if (state == IDLE) begin
        bank <= pick;
        word_addr <= '0;
      end
      if (ram_rd_en) word_addr <= word_addr + 1'b1;
      if (state == CLEAR) begin
        bank_cnt <= bank_cnt + 1'b1;
        last_bank <= bank;
      end
    end
  end
  ts_skid_fifo #(.DEPTH(FIFO_DEPTH), .W(34)) u_fifo (
    .clk(clk_pcie),
    .rst(rst_pcie),
    .push(inflight),
    .pop(pop),
    .din({tag_sof, tag_eof, ram_rd_data}),
    .dout(head),
    .empty(empty),
    .cnt(fifo_cnt)
  );
  always_comb begin
    ram_rd_addr = {bank, word_addr};
    ram_clr_1 = (state == CLEAR) & ~bank;
    ram_clr_2 = (state == CLEAR) & bank;
    busy = state != IDLE;
    dma_dout_en = ~empty;
    {dma_sof, dma_eof, dma_dout} = empty ? 34'd0 : head;
  end
endmodule
